// File: rtl/vga_pkg.sv
// Shared timing constants for the video pipeline: 800x600 @ 60 Hz with a 40 MHz pixel clock.
package vga_pkg;

  localparam int CNT_W = 11;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam int HOR_TOTAL      = 1056;
  localparam int HOR_VISIBLE    = 800;
  localparam int HOR_SYNC_START = 840;
  localparam int HOR_SYNC_STOP  = 968;

  localparam int VER_TOTAL      = 628;
  localparam int VER_VISIBLE    = 600;
  localparam int VER_SYNC_START = 601;
  localparam int VER_SYNC_STOP  = 605;

  // Half-open window test used for the sync pulses: lo <= v < hi.
  function automatic logic in_window(cnt_t v, cnt_t lo, cnt_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Raster timing bundle: counters plus sync/blank strobes, produced by vga_timing.
interface timing_if;
  import vga_pkg::*;

  cnt_t hcount;
  cnt_t vcount;
  logic hsync;
  logic vsync;
  logic hblnk;
  logic vblnk;

  modport out_vga_timing (output hcount, vcount, hsync, vsync, hblnk, vblnk);
  modport in_vga_timing  (input  hcount, vcount, hsync, vsync, hblnk, vblnk);

endinterface

// File: rtl/vga_timing_axis.sv
// One raster axis: wrapping counter with sync and blank strobes decoded from the next count.
module timing_axis
  import vga_pkg::*;
#(
  parameter int TOTAL      = HOR_TOTAL,
  parameter int VISIBLE    = HOR_VISIBLE,
  parameter int SYNC_START = HOR_SYNC_START,
  parameter int SYNC_STOP  = HOR_SYNC_STOP
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output cnt_t cnt,
  output logic wrap,
  output logic sync,
  output logic blnk
);

  localparam cnt_t LAST    = cnt_t'(TOTAL - 1);
  localparam cnt_t VIS     = cnt_t'(VISIBLE);
  localparam cnt_t SYNC_LO = cnt_t'(SYNC_START);
  localparam cnt_t SYNC_HI = cnt_t'(SYNC_STOP);

  cnt_t cnt_q, cnt_d;
  logic sync_q, sync_d;
  logic blnk_q, blnk_d;

  // Terminal count; the vertical axis uses this as its advance qualifier.
  assign wrap = (cnt_q == LAST);

  always_comb begin
    // NOTE: every output gets a hold value first so no path through this block infers a latch.
    cnt_d  = cnt_q;
    sync_d = sync_q;
    blnk_d = blnk_q;
    if (en) begin
      cnt_d  = wrap ? '0 : cnt_q + cnt_t'(1);
      // Decode from the next count so the registered strobes line up with the registered count.
      sync_d = in_window(cnt_d, SYNC_LO, SYNC_HI);
      blnk_d = (cnt_d >= VIS);
    end
  end

  // NOTE: sequential state uses non-blocking assignments and resets asynchronously to the visible origin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      sync_q <= 1'b0;
      blnk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sync_q <= sync_d;
      blnk_q <= blnk_d;
    end
  end

  assign cnt  = cnt_q;
  assign sync = sync_q;
  assign blnk = blnk_q;

endmodule

// File: rtl/vga_timing.sv
// 800x600 @ 60 Hz raster timing generator, first stage of the video pipeline.
// Optional frame_tick output is built when VGA_TIMING_FRAME_TICK_EN is defined.
module vga_timing
  import vga_pkg::*;
#(
  parameter int H_TOTAL      = HOR_TOTAL,
  parameter int H_VISIBLE    = HOR_VISIBLE,
  parameter int H_SYNC_START = HOR_SYNC_START,
  parameter int H_SYNC_STOP  = HOR_SYNC_STOP,
  parameter int V_TOTAL      = VER_TOTAL,
  parameter int V_VISIBLE    = VER_VISIBLE,
  parameter int V_SYNC_START = VER_SYNC_START,
  parameter int V_SYNC_STOP  = VER_SYNC_STOP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_en,
  timing_if.out_vga_timing  tim
`ifdef VGA_TIMING_FRAME_TICK_EN
  , output logic            frame_tick
`endif
);

  cnt_t h_cnt, v_cnt;
  logic h_wrap, v_wrap;
  logic h_sync, v_sync;
  logic h_blnk, v_blnk;
  logic v_en;

  timing_axis #(
    .TOTAL      (H_TOTAL),
    .VISIBLE    (H_VISIBLE),
    .SYNC_START (H_SYNC_START),
    .SYNC_STOP  (H_SYNC_STOP)
  ) u_h_axis (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pix_en),
    .cnt   (h_cnt),
    .wrap  (h_wrap),
    .sync  (h_sync),
    .blnk  (h_blnk)
  );

  // The line counter steps on the same edge that wraps the pixel counter.
  assign v_en = pix_en & h_wrap;

  timing_axis #(
    .TOTAL      (V_TOTAL),
    .VISIBLE    (V_VISIBLE),
    .SYNC_START (V_SYNC_START),
    .SYNC_STOP  (V_SYNC_STOP)
  ) u_v_axis (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (v_en),
    .cnt   (v_cnt),
    .wrap  (v_wrap),
    .sync  (v_sync),
    .blnk  (v_blnk)
  );

  assign tim.hcount = h_cnt;
  assign tim.vcount = v_cnt;
  assign tim.hsync  = h_sync;
  assign tim.vsync  = v_sync;
  assign tim.hblnk  = h_blnk;
  assign tim.vblnk  = v_blnk;

`ifdef VGA_TIMING_FRAME_TICK_EN
  logic frame_tick_q, frame_tick_d;

  // High on the edge that returns the raster to 0,0; never in the reset state itself.
  always_comb begin
    frame_tick_d = pix_en & h_wrap & v_wrap;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_tick_q <= 1'b0;
    else        frame_tick_q <= frame_tick_d;
  end

  assign frame_tick = frame_tick_q;
`else
  logic unused_v_wrap;
  assign unused_v_wrap = v_wrap;
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Bench for vga_timing: a default-size instance and a shrunken-raster instance run side by side,
// checked against a table of hand-derived points and a cycle-by-cycle scoreboard model.
module tb_vga_timing;
  import vga_pkg::*;

  typedef struct {
    int ht, hv, hss, hse, vt, vv, vss, vse;
  } tparam_t;

  typedef struct {
    logic [25:0] d;
    logic [25:0] s;
    bit          ft_d;
    bit          ft_s;
  } sb_t;

  typedef struct {
    string       name;
    bit          sel;      // 0: default instance, 1: small instance
    int          cyc;      // enabled cycles since reset release
    logic [25:0] exp;      // {hcount, vcount, hsync, vsync, hblnk, vblnk}
  } vec_t;

  localparam int S_HT = 20, S_HV = 12, S_HSS = 14, S_HSE = 17;
  localparam int S_VT = 10, S_VV = 6,  S_VSS = 7,  S_VSE = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_en = 1'b0;
  always #5 clk = ~clk;

  timing_if tim_d();
  timing_if tim_s();

`ifdef VGA_TIMING_FRAME_TICK_EN
  logic ft_d, ft_s;
`endif

  vga_timing dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .pix_en (pix_en),
    .tim    (tim_d)
`ifdef VGA_TIMING_FRAME_TICK_EN
    , .frame_tick (ft_d)
`endif
  );

  vga_timing #(
    .H_TOTAL (S_HT), .H_VISIBLE (S_HV), .H_SYNC_START (S_HSS), .H_SYNC_STOP (S_HSE),
    .V_TOTAL (S_VT), .V_VISIBLE (S_VV), .V_SYNC_START (S_VSS), .V_SYNC_STOP (S_VSE)
  ) dut_s (
    .clk    (clk),
    .rst_n  (rst_n),
    .pix_en (pix_en),
    .tim    (tim_s)
`ifdef VGA_TIMING_FRAME_TICK_EN
    , .frame_tick (ft_s)
`endif
  );

  int tests = 0;
  int fails = 0;
  tparam_t pd, ps;
  int mh_d, mv_d, mh_s, mv_s;
  sb_t sb_q[$];
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      if (fails >= 50) begin
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
      end
    end
  endtask

  function automatic logic [25:0] model_obs(tparam_t p, int h, int v);
    logic hs, vs, hb, vb;
    hs = (h >= p.hss) && (h < p.hse);
    vs = (v >= p.vss) && (v < p.vse);
    hb = (h >= p.hv);
    vb = (v >= p.vv);
    return {h[10:0], v[10:0], hs, vs, hb, vb};
  endfunction

  function automatic logic [25:0] obs_d();
    return {tim_d.hcount, tim_d.vcount, tim_d.hsync, tim_d.vsync, tim_d.hblnk, tim_d.vblnk};
  endfunction

  function automatic logic [25:0] obs_s();
    return {tim_s.hcount, tim_s.vcount, tim_s.hsync, tim_s.vsync, tim_s.hblnk, tim_s.vblnk};
  endfunction

  task automatic model_step(input tparam_t p, input bit en, inout int h, inout int v,
                            output bit ft);
    ft = 1'b0;
    if (en) begin
      if (h == p.ht - 1) begin
        h = 0;
        if (v == p.vt - 1) begin
          v  = 0;
          ft = 1'b1;
        end else begin
          v++;
        end
      end else begin
        h++;
      end
    end
  endtask

  // Drive pix_en, push the model's prediction, then pop and compare one edge later.
  task automatic tick(input bit en);
    sb_t e;
    bit  f;
    pix_en = en;
    model_step(pd, en, mh_d, mv_d, f);
    e.ft_d = f;
    e.d    = model_obs(pd, mh_d, mv_d);
    model_step(ps, en, mh_s, mv_s, f);
    e.ft_s = f;
    e.s    = model_obs(ps, mh_s, mv_s);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("sb_dflt", {6'b0, obs_d()}, {6'b0, e.d});
    check("sb_small", {6'b0, obs_s()}, {6'b0, e.s});
`ifdef VGA_TIMING_FRAME_TICK_EN
    check("sb_tick_dflt", {31'b0, ft_d}, {31'b0, e.ft_d});
    check("sb_tick_small", {31'b0, ft_s}, {31'b0, e.ft_s});
`endif
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    pix_en = 1'b0;
    #20;
    mh_d = 0; mv_d = 0; mh_s = 0; mv_s = 0;
    sb_q.delete();
    check("reset_dflt", {6'b0, obs_d()}, 32'h0);
    check("reset_small", {6'b0, obs_s()}, 32'h0);
`ifdef VGA_TIMING_FRAME_TICK_EN
    check("reset_tick", {30'b0, ft_d, ft_s}, 32'h0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  function automatic vec_t mk(string n, bit sel, int cyc, int hc, int vc,
                              bit hs, bit vs, bit hb, bit vb);
    vec_t v;
    v.name = n;
    v.sel  = sel;
    v.cyc  = cyc;
    v.exp  = {hc[10:0], vc[10:0], hs, vs, hb, vb};
    return v;
  endfunction

  initial begin
    int cyc;
    int hs_cnt, hb_cnt, vs_cnt, vb_cnt, tick_cnt, en_cycles;
    bit seen_vs;

    pd = '{1056, 800, 840, 968, 628, 600, 601, 605};
    ps = '{S_HT, S_HV, S_HSS, S_HSE, S_VT, S_VV, S_VSS, S_VSE};

    // Hand-derived raster points, ordered by enabled cycles since reset release.
    vecs.push_back(mk("first_edge_dflt",   0,    1,    1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("first_edge_small",  1,    1,    1, 0, 0, 0, 0, 0));
    vecs.push_back(mk("s_hblnk_rise",      1,   12,   12, 0, 0, 0, 1, 0));
    vecs.push_back(mk("s_hsync_rise",      1,   14,   14, 0, 1, 0, 1, 0));
    vecs.push_back(mk("s_hsync_fall",      1,   17,   17, 0, 0, 0, 1, 0));
    vecs.push_back(mk("s_line_wrap",       1,   20,    0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("s_vblnk_rise",      1,  120,    0, 6, 0, 0, 0, 1));
    vecs.push_back(mk("s_vsync_rise",      1,  140,    0, 7, 0, 1, 0, 1));
    vecs.push_back(mk("s_vsync_last_pix",  1,  179,   19, 8, 0, 1, 1, 1));
    vecs.push_back(mk("s_vsync_fall",      1,  180,    0, 9, 0, 0, 0, 1));
    vecs.push_back(mk("s_frame_last_pix",  1,  199,   19, 9, 0, 0, 1, 1));
    vecs.push_back(mk("s_frame_wrap",      1,  200,    0, 0, 0, 0, 0, 0));
    vecs.push_back(mk("d_last_visible",    0,  799,  799, 0, 0, 0, 0, 0));
    vecs.push_back(mk("d_hblnk_rise",      0,  800,  800, 0, 0, 0, 1, 0));
    vecs.push_back(mk("d_pre_hsync",       0,  839,  839, 0, 0, 0, 1, 0));
    vecs.push_back(mk("d_hsync_rise",      0,  840,  840, 0, 1, 0, 1, 0));
    vecs.push_back(mk("d_hsync_last",      0,  967,  967, 0, 1, 0, 1, 0));
    vecs.push_back(mk("d_hsync_fall",      0,  968,  968, 0, 0, 0, 1, 0));
    vecs.push_back(mk("d_line_last_pix",   0, 1055, 1055, 0, 0, 0, 1, 0));
    vecs.push_back(mk("d_line_wrap",       0, 1056,    0, 1, 0, 0, 0, 0));
    vecs.push_back(mk("d_line1_hsync",     0, 1896,  840, 1, 1, 0, 1, 0));

    do_reset();
    cyc = 0;
    foreach (vecs[i]) begin
      while (cyc < vecs[i].cyc) begin
        tick(1'b1);
        cyc++;
      end
      check(vecs[i].name, {6'b0, vecs[i].sel ? obs_s() : obs_d()}, {6'b0, vecs[i].exp});
    end

    // Asynchronous reset mid-line: outputs clear before the next clock edge.
    do_reset();
    repeat (500) tick(1'b1);
    check("pre_async_hcount", {21'b0, tim_d.hcount}, 32'd500);
    #3;
    rst_n = 1'b0;
    #1;
    check("async_rst_dflt", {6'b0, obs_d()}, 32'h0);
    check("async_rst_small", {6'b0, obs_s()}, 32'h0);

    // Freeze at hcount=839 for 37 cycles, then the next enabled edge raises hsync.
    do_reset();
    repeat (839) tick(1'b1);
    repeat (37) tick(1'b0);
    check("freeze_state", {6'b0, obs_d()}, {6'b0, 11'd839, 11'd0, 4'b0010});
    tick(1'b1);
    check("unfreeze_hsync", {6'b0, obs_d()}, {6'b0, 11'd840, 11'd0, 4'b1010});

    // Strobe widths over one full line starting at hcount=0.
    repeat (216) tick(1'b1);
    check("line_start_hcount", {21'b0, tim_d.hcount}, 32'd0);
    hs_cnt = 0;
    hb_cnt = 0;
    for (int i = 0; i < 1056; i++) begin
      tick(1'b1);
      hs_cnt += int'(tim_d.hsync);
      hb_cnt += int'(tim_d.hblnk);
    end
    check("hsync_width", hs_cnt, 32'd128);
    check("hblnk_width", hb_cnt, 32'd256);
    check("line_end_pos", {6'b0, obs_d()}, {6'b0, 11'd0, 11'd2, 4'b0000});

    // One full small-raster frame: vertical strobe widths, vsync start position, frame tick.
    do_reset();
    vs_cnt   = 0;
    vb_cnt   = 0;
    tick_cnt = 0;
    seen_vs  = 1'b0;
    for (int i = 0; i < S_HT * S_VT; i++) begin
      tick(1'b1);
      vs_cnt += int'(tim_s.vsync);
      vb_cnt += int'(tim_s.vblnk);
      if (tim_s.vsync && !seen_vs) begin
        seen_vs = 1'b1;
        check("vsync_start_pos", {10'b0, tim_s.hcount, tim_s.vcount}, {10'b0, 11'd0, 11'd7});
      end
`ifdef VGA_TIMING_FRAME_TICK_EN
      if (ft_s) begin
        tick_cnt++;
        check("tick_at_origin", {10'b0, tim_s.hcount, tim_s.vcount}, 32'h0);
      end
`endif
    end
    check("vsync_width", vs_cnt, 32'(2 * S_HT));
    check("vblnk_width", vb_cnt, 32'(4 * S_HT));
    check("vsync_seen", {31'b0, seen_vs}, 32'd1);
`ifdef VGA_TIMING_FRAME_TICK_EN
    check("ticks_per_frame", tick_cnt, 32'd1);
`endif

    // Random pix_en until three small frames have elapsed.
    do_reset();
    en_cycles = 0;
    while (en_cycles < 3 * S_HT * S_VT) begin
      bit e;
      e = ($urandom_range(0, 9) < 7);
      tick(e);
      if (e) en_cycles++;
    end
    check("rand_small_origin", {6'b0, obs_s()}, 32'h0);
    check("rand_dflt_pos", {6'b0, obs_d()}, {6'b0, 11'd600, 11'd0, 4'b0000});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vga_timing.md
# vga_timing

Generates the 800x600 @ 60 Hz raster timing (40 MHz pixel clock) and drives a `timing_if` `out_vga_timing` modport. It is the first stage of the video pipeline: the background, sprite and overlay draw stages consume its `timing_if` and forward `vga_if` downstream. All outputs are registered, so downstream stages see glitch-free, aligned counters and strobes.

## Interface
Parameters (defaults come from `vga_pkg`):
- `H_TOTAL`, 1056, pixels per line.
- `H_VISIBLE`, 800, active pixels per line.
- `H_SYNC_START`, 840, first hcount with hsync high.
- `H_SYNC_STOP`, 968, first hcount with hsync low again.
- `V_TOTAL`, 628, lines per frame.
- `V_VISIBLE`, 600, active lines.
- `V_SYNC_START`, 601, first vcount with vsync high.
- `V_SYNC_STOP`, 605, first vcount with vsync low again.

Ports:
- `clk` input 1: 40 MHz pixel clock.
- `rst_n` input 1: asynchronous, active-low reset.
- `pix_en` input 1: advance enable; counters hold while low (tie high in the normal build).
- `tim` `timing_if.out_vga_timing`: `hcount[10:0]`, `vcount[10:0]`, `hsync`, `vsync`, `hblnk`, `vblnk`.
- `frame_tick` output 1: present only with `VGA_TIMING_FRAME_TICK_EN` defined.

## Operation
- Internal `h_cnt` and `v_cnt` are 11-bit.
- On `clk` with `pix_en=1`:
  - `h_cnt` increments. At `H_TOTAL-1` it wraps to 0 and generates `h_wrap`.
  - `v_cnt` increments only on `h_wrap`. At `V_TOTAL-1` (coincident with `h_wrap`) it wraps to 0.
- With `pix_en=0`, all state and outputs hold.
- Strobes are decoded from the *next* counter values and registered, so they are coherent with the registered hcount/vcount on the same cycle:
  - `hblnk` = hcount >= `H_VISIBLE`
  - `hsync` = `H_SYNC_START` <= hcount < `H_SYNC_STOP`
  - `vblnk` = vcount >= `V_VISIBLE`
  - `vsync` = `V_SYNC_START` <= vcount < `V_SYNC_STOP`
- Sync polarity is positive.
- vsync and vblnk depend only on vcount. They change at the first pixel (hcount=0) of a line.
- Reset (`rst_n` low, asynchronous, any time including mid-line or mid-frame):
  - all outputs go to 0 immediately.
  - hcount=0 and vcount=0 is a valid visible state.
- After reset release, the first enabled edge moves to hcount=1, vcount=0.
- Counter values never exceed `H_TOTAL-1` / `V_TOTAL-1`. No out-of-range state is reachable.

## Timing
- Output latency: 0 cycles relative to counter state. All six signals are updated by the same edge.
- Line period: `H_TOTAL` enabled cycles. Frame period: `H_TOTAL*V_TOTAL` = 663168 enabled cycles.
- hsync width: 128 cycles. hblnk width: 256 cycles. vsync width: 4 lines. vblnk width: 28 lines.
- Simultaneous h-wrap and v-wrap (hcount=1055, vcount=627): the next enabled edge gives hcount=0 and vcount=0 with all strobes low.
- Reset deassertion must be synchronised to `clk` at the top level. This block does not resynchronise it.

## Configuration
- `VGA_TIMING_FRAME_TICK_EN` defined:
  - adds the `frame_tick` output.
  - registered one-cycle pulse, high exactly when the outputs show hcount=0, vcount=0 after an enabled edge.
  - 0 in reset.
  - does not assert in the reset state itself.
  - used by game logic as the 60 Hz update strobe.
- Not defined: the port and its logic are absent. All other behaviour is identical.

## Structure
- `vga_pkg` holds the default timing constants (`HOR_*`, `VER_*`) and the counter width localparam (11).
- Sub-module `timing_axis`:
  - parameterised by total, visible, sync start and sync stop.
  - inputs: `clk`, `rst_n`, `en`.
  - outputs: `cnt`, `wrap`, `sync`, `blnk`.
  - instantiated twice: horizontal with `en=pix_en`; vertical with `en=pix_en & h_wrap`.
- The top level only wires the two instances to `tim` and, under the macro, generates `frame_tick`.

## Test plan
- Reset, then release; 1 cycle -> hcount=1, vcount=0, all strobes 0. Async assert mid-line at hcount=500 -> outputs 0 before the next edge.
- Run 1056 cycles from hcount=0:
  - hsync rises when hcount=840 and falls at 968.
  - hblnk rises at 800.
  - hcount wraps 1055->0 while vcount increments.
- Run a full frame (663168 cycles):
  - vsync high for exactly 4*1056 cycles starting at vcount=601, hcount=0.
  - vblnk high from vcount=600.
  - wraps to 0,0 at 627/1055.
- `pix_en` low for 37 cycles at hcount=839 -> all outputs frozen. Re-enable -> hsync rises on the next edge.
- With `VGA_TIMING_FRAME_TICK_EN` -> exactly one `frame_tick` per 663168 cycles, coincident with hcount=0, vcount=0. Without it -> the build elaborates with the port absent.
- Random `pix_en` over 3 frames -> the scoreboard reference model matches all six outputs every cycle.
